// File: rtl/dram_pkg.sv
// Shared types and constants for the RAS/CAS DRAM responder model.
package dram_pkg;

    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned CAS_LAT_MIN = 1;
    localparam int unsigned CAS_LAT_MAX = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        READ_LAT,
        DATA
    } dram_state_e;

    function automatic bit cas_lat_ok(input int unsigned lat);
        return (lat >= CAS_LAT_MIN) && (lat <= CAS_LAT_MAX);
    endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous RAM: write at the edge, registered read held until the next read.
module dram_array
    import dram_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dram_rc_responder.sv
// DRAM device model answering the RAS/CAS command interface with a programmable
// CAS latency; the read word is captured at the CAS edge and presented on Q in DATA.
module dram_rc_responder
    import dram_pkg::*;
#(
    parameter int unsigned ROW_BITS = 6,
    parameter int unsigned COL_BITS = 10,
    parameter int unsigned CAS_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSn,
    input  logic              WEn,
    input  logic              RASn,
    input  logic              CASn,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    output logic              Q_valid,
    output logic              row_open
);

    localparam int unsigned ARR_AW = ROW_BITS + COL_BITS;

    if (!cas_lat_ok(CAS_LAT)) begin : g_bad_cas_lat
        $error("dram_rc_responder: CAS_LAT must be in 1..7");
    end
    if (ROW_BITS > ADDR_W || COL_BITS > ADDR_W) begin : g_bad_addr_bits
        $error("dram_rc_responder: ROW_BITS/COL_BITS must not exceed 11");
    end

    dram_state_e         state, state_n;
    logic [ROW_BITS-1:0] row, row_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                we_c, re_c;
    logic                q_valid_r, row_open_r;
    logic [DATA_W-1:0]   rd_data;
    logic                ras_c, cas_rd_c, cas_wr_c;
    logic                unused_addr;

    // High address bits are deliberately dropped so the array aliases.
    assign unused_addr = ^A;

    assign ras_c    = !RASn &&  CASn;
    assign cas_rd_c =  RASn && !CASn &&  WEn;
    assign cas_wr_c =  RASn && !CASn && !WEn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            cnt        <= '0;
            q_valid_r  <= 1'b0;
            row_open_r <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            cnt        <= cnt_n;
            q_valid_r  <= (state_n == DATA);
            row_open_r <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        we_c    = 1'b0;
        re_c    = 1'b0;
        if (CSn) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ras_c) begin
                        row_n   = A[ROW_BITS-1:0];
                        state_n = ACTIVE;
                    end
                end
                ACTIVE, DATA: begin
                    if (ras_c) begin
                        row_n   = A[ROW_BITS-1:0];
                        state_n = ACTIVE;
                    end else if (cas_wr_c) begin
                        we_c    = 1'b1;
                        state_n = ACTIVE;
                    end else if (cas_rd_c) begin
                        re_c    = 1'b1;
                        cnt_n   = CNT_W'(CAS_LAT - 1);
                        state_n = (CAS_LAT == 1) ? DATA : READ_LAT;
                    end
                end
                READ_LAT: begin
                    // Last latency edge is the one that would take cnt to zero.
                    if (cnt > CNT_W'(1)) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else begin
                        cnt_n   = '0;
                        state_n = DATA;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    dram_array #(
        .AW (ARR_AW)
    ) u_array (
        .clk   (clk),
        .we    (we_c && !rst),
        .re    (re_c && !rst),
        .addr  ({row, A[COL_BITS-1:0]}),
        .wdata (D),
        .rdata (rd_data)
    );

    assign Q        = q_valid_r ? rd_data : 'z;
    assign Q_valid  = q_valid_r;
    assign row_open = row_open_r;

endmodule

// File: tb/tb_dram_rc_responder.sv
// Directed bench for dram_rc_responder: vector table plus latency/reset corner sequences.
module tb_dram_rc_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        CSn, WEn, RASn, CASn;
    logic [10:0] A;
    logic [31:0] D;
    wire  [31:0] Q, Q1;
    logic        Q_valid, row_open, Q_valid1, row_open1;

    int n_checks = 0;
    int n_fail   = 0;

    dram_rc_responder dut (
        .clk(clk), .rst(rst), .CSn(CSn), .WEn(WEn), .RASn(RASn), .CASn(CASn),
        .A(A), .D(D), .Q(Q), .Q_valid(Q_valid), .row_open(row_open)
    );

    dram_rc_responder #(.ROW_BITS(2), .COL_BITS(3), .CAS_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .CSn(CSn), .WEn(WEn), .RASn(RASn), .CASn(CASn),
        .A(A), .D(D), .Q(Q1), .Q_valid(Q_valid1), .row_open(row_open1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        csn, wen, rasn, casn;
        logic [10:0] a;
        logic [31:0] d;
        logic        v;
        logic [31:0] q;
        logic        open;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic csn, input logic wen, input logic rasn, input logic casn,
                         input logic [10:0] a, input logic [31:0] d);
        CSn = csn; WEn = wen; RASn = rasn; CASn = casn; A = a; D = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input logic v, input logic [31:0] q, input logic open);
        check({name, " Q"}, Q, v ? q : 32'hz);
        check({name, " Q_valid"}, 32'(Q_valid), 32'(v));
        check({name, " row_open"}, 32'(row_open), 32'(open));
    endtask

    task automatic add(input logic csn, input logic wen, input logic rasn, input logic casn,
                       input logic [10:0] a, input logic [31:0] d,
                       input logic v, input logic [31:0] q, input logic open);
        vec_t t;
        t.csn = csn; t.wen = wen; t.rasn = rasn; t.casn = casn; t.a = a; t.d = d;
        t.v = v; t.q = q; t.open = open;
        vt.push_back(t);
    endtask

    initial begin
        // csn wen rasn casn a d | valid q open
        for (int i = 0; i < 5; i++) add(1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 11'd5,     0,             0, 0, 1);  // RAS row 5
        add(0, 0, 1, 0, 11'd3,     32'hDEADBEEF,  0, 0, 1);  // write col 3
        add(0, 1, 1, 0, 11'd3,     0,             0, 0, 1);  // read col 3 -> READ_LAT
        add(0, 1, 1, 1, 0,         0,             1, 32'hDEADBEEF, 1);
        add(0, 1, 1, 1, 0,         0,             1, 32'hDEADBEEF, 1);
        add(1, 1, 1, 1, 0,         0,             0, 0, 0);
        add(0, 1, 0, 1, 11'd7,     0,             0, 0, 1);  // preload row 7 col 0x12
        add(0, 0, 1, 0, 11'h12,    32'h12345678,  0, 0, 1);
        add(1, 1, 1, 1, 0,         0,             0, 0, 0);
        add(0, 1, 1, 1, 0,         0,             0, 0, 0);  // wrapper pattern
        add(0, 1, 0, 1, 11'd7,     0,             0, 0, 1);
        add(0, 1, 1, 1, 0,         0,             0, 0, 1);
        add(0, 1, 1, 0, 11'h12,    0,             0, 0, 1);
        add(0, 1, 1, 1, 0,         0,             1, 32'h12345678, 1);
        add(0, 1, 1, 1, 0,         0,             1, 32'h12345678, 1);
        add(0, 1, 1, 1, 0,         0,             1, 32'h12345678, 1);
        add(1, 1, 1, 1, 0,         0,             0, 0, 0);
        add(0, 1, 0, 1, 11'd1,     0,             0, 0, 1);  // independent rows
        add(0, 0, 1, 0, 11'd0,     32'hA,         0, 0, 1);
        add(0, 1, 0, 1, 11'd2,     0,             0, 0, 1);
        add(0, 0, 1, 0, 11'd0,     32'hB,         0, 0, 1);
        add(0, 1, 1, 0, 11'd0,     0,             0, 0, 1);
        add(0, 1, 1, 1, 0,         0,             1, 32'hB, 1);
        add(0, 1, 0, 1, 11'd1,     0,             0, 0, 1);  // RAS from DATA
        add(0, 1, 1, 0, 11'd0,     0,             0, 0, 1);
        add(0, 1, 1, 1, 0,         0,             1, 32'hA, 1);
        add(0, 1, 0, 1, 11'h41,    0,             0, 0, 1);  // aliased row 1
        add(0, 1, 1, 0, 11'h400,   0,             0, 0, 1);  // aliased col 0
        add(0, 1, 1, 1, 0,         0,             1, 32'hA, 1);
        add(0, 0, 1, 0, 11'd5,     32'h55,        0, 0, 1);  // write from DATA
        add(0, 1, 1, 0, 11'd5,     0,             0, 0, 1);  // read right after write
        add(0, 1, 1, 1, 0,         0,             1, 32'h55, 1);
        add(0, 1, 1, 0, 11'd0,     0,             0, 0, 1);  // read from DATA
        add(0, 1, 1, 1, 0,         0,             1, 32'hA, 1);
        add(0, 1, 0, 0, 11'd2,     0,             1, 32'hA, 1);  // RAS+CAS ignored
        add(1, 1, 1, 1, 0,         0,             0, 0, 0);
        add(0, 1, 1, 0, 11'd3,     0,             0, 0, 0);  // CAS alone in IDLE
        add(0, 1, 0, 0, 11'd3,     0,             0, 0, 0);  // RAS+CAS in IDLE
        add(0, 1, 1, 1, 0,         0,             0, 0, 0);

        rst = 1'b1;
        drive(1, 1, 1, 1, 0, 0);
        step();
        step();
        expect3("reset", 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].csn, vt[i].wen, vt[i].rasn, vt[i].casn, vt[i].a, vt[i].d);
            step();
            expect3($sformatf("vec%0d", i), vt[i].v, vt[i].q, vt[i].open);
        end

        // CSn high during READ_LAT discards the read
        drive(0, 1, 0, 1, 11'd5, 0); step();
        drive(0, 1, 1, 0, 11'd3, 0); step();
        expect3("rl_enter", 0, 0, 1);
        drive(1, 1, 1, 1, 0, 0); step();
        expect3("rl_abort", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 0, 0); step();
            expect3($sformatf("rl_after%0d", i), 0, 0, 0);
        end

        // rst in DATA, then rst masking a write, array preserved
        drive(0, 1, 0, 1, 11'd5, 0); step();
        drive(0, 1, 1, 0, 11'd3, 0); step();
        drive(0, 1, 1, 1, 0, 0);     step();
        expect3("data_pre_rst", 1, 32'hDEADBEEF, 1);
        rst = 1'b1; step();
        expect3("rst_in_data", 0, 0, 0);
        rst = 1'b0;
        drive(0, 1, 0, 1, 11'd5, 0); step();
        rst = 1'b1;
        drive(0, 0, 1, 0, 11'd3, 32'h0); step();
        expect3("rst_write", 0, 0, 0);
        rst = 1'b0;
        drive(0, 1, 0, 1, 11'd5, 0); step();
        drive(0, 1, 1, 0, 11'd3, 0); step();
        drive(0, 1, 1, 1, 0, 0);     step();
        expect3("post_rst_read", 1, 32'hDEADBEEF, 1);

        // CAS_LAT=1 instance: data valid right after the read CAS edge
        drive(1, 1, 1, 1, 0, 0);     step();
        drive(0, 1, 0, 1, 11'd1, 0); step();
        drive(0, 0, 1, 0, 11'd2, 32'hC0FFEE); step();
        drive(0, 1, 1, 0, 11'd2, 0); step();
        check("lat1 Q", Q1, 32'hC0FFEE);
        check("lat1 Q_valid", 32'(Q_valid1), 32'd1);
        check("lat2 not yet", 32'(Q_valid), 32'd0);
        drive(0, 1, 1, 0, 11'hA, 0); step();
        check("lat1 alias Q", Q1, 32'hC0FFEE);
        check("lat2 valid", 32'(Q_valid), 32'd1);
        drive(1, 1, 1, 1, 0, 0); step();
        check("lat1 close", 32'(Q_valid1), 32'd0);
        check("lat1 row_open", 32'(row_open1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
